// File: rtl/vedic_mul8_seq.sv
// Sequential 8x8 unsigned multiplier: four 4x4 partial products accumulated through one shared 12-bit adder.
// Latency 4 cycles from accepted start to done; start is ignored while busy (no other backpressure).

module full_adder12 (
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  output logic [11:0] s_o
);

  logic [11:0] c;

  assign c[0] = 1'b0;

  // Carry out of the MSB is intentionally dropped: the accumulated sum is bounded below 4096.
  for (genvar i = 0; i < 12; i++) begin : g_bit
    assign s_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    if (i < 11) begin : g_carry
      assign c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

module vedic_mul8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD1,
    S_ADD2,
    S_ADD3,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  ra_q, ra_d;
  logic [7:0]  rb_q, rb_d;
  logic [11:0] acc_q, acc_d;
  logic [15:0] p_q, p_d;

  logic [7:0]  q0, q1, q2, q3;
  logic [11:0] opa, opb, sum;

  assign q0 = ra_q[3:0] * rb_q[3:0];
  assign q1 = ra_q[7:4] * rb_q[3:0];
  assign q2 = ra_q[3:0] * rb_q[7:4];
  assign q3 = ra_q[7:4] * rb_q[7:4];

  full_adder12 u_add (
    .a_i (opa),
    .b_i (opb),
    .s_o (sum)
  );

  // acc holds the product shifted right by 4; q0[3:0] is appended as the low nibble at the end.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    p_d     = p_q;
    opa     = 12'd0;
    opb     = 12'd0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          state_d = S_ADD1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD1: begin
        opa     = {4'b0, q1};
        opb     = {4'b0, q2};
        acc_d   = sum;
        state_d = S_ADD2;
      end
      S_ADD2: begin
        opa     = acc_q;
        opb     = {8'b0, q0[7:4]};
        acc_d   = sum;
        state_d = S_ADD3;
      end
      S_ADD3: begin
        opa     = acc_q;
        opb     = {q3, 4'b0};
        p_d     = {sum, q0[3:0]};
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ra_q    <= 8'd0;
      rb_q    <= 8'd0;
      acc_q   <= 12'd0;
      p_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q == S_ADD1) || (state_q == S_ADD2) || (state_q == S_ADD3);
  assign done = (state_q == S_DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_vedic_mul8_seq.sv
// Scoreboard bench for vedic_mul8_seq: directed vectors plus reference-model random pairs.
module tb_vedic_mul8_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] p;

  vedic_mul8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          ncyc   = 0;
  logic [15:0] exp_q[$];
  int          exp_c[$];

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, ncyc);
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  logic [15:0] p_hold    = 16'd0;
  logic        prev_done = 1'b0;
  int          busy_run  = 0;

  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_p", p, 0);
      p_hold    = 16'd0;
      prev_done = 1'b0;
      busy_run  = 0;
    end else begin
      check("busy_done_excl", busy & done, 0);
      check("done_single", prev_done & done, 0);
      if (busy) busy_run++;
      if (done) begin
        check("busy_len", busy_run, 3);
        busy_run = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("product", p, exp_q.pop_front());
          check("latency", ncyc, exp_c.pop_front());
        end
        p_hold = p;
      end else begin
        check("p_hold", p, p_hold);
      end
      prev_done = done;
    end
  end

  // Drive at negedge+1; the next rising edge accepts, done appears 4 falling edges later.
  task automatic go_now(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] expv);
    a     = av;
    b     = bv;
    start = 1'b1;
    exp_q.push_back(expv);
    exp_c.push_back(ncyc + 4);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic go(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] expv);
    @(negedge clk);
    #1;
    go_now(av, bv, expv);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    idle(2);
    #1;
    rst_n = 1'b1;

    go(8'h00, 8'h00, 16'h0000);
    idle(4);
    go(8'hFF, 8'hFF, 16'hFE01);
    idle(4);
    go(8'h12, 8'h34, 16'h03A8);
    idle(4);

    // Back-to-back: second start presented while done is high.
    go(8'hA5, 8'h5A, 16'h3A02);
    idle(3);
    go(8'h0F, 8'h10, 16'h00F0);
    idle(4);

    // start pulsed and operands toggled while busy must be ignored.
    go(8'h9C, 8'h37, 16'h2184);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      start = (i != 1);
      a     = 8'($urandom);
      b     = 8'($urandom);
    end
    @(negedge clk);
    #1;
    start = 1'b0;
    idle(2);

    // Reset during ADD2 aborts the operation with no done.
    go(8'hFF, 8'hFF, 16'hFE01);
    idle(2);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_c.delete();
    #1;
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_p", p, 0);
    idle(3);
    #1;
    rst_n = 1'b1;
    go_now(8'h03, 8'h07, 16'h0015);
    idle(4);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      go(ra, rb, 16'(ra * rb));
      idle(($urandom_range(0, 3) == 0) ? 4 : 3);
    end

    begin
      int guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
    end
    check("drain", exp_q.size(), 0);
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
